csa_operand_collector: RTL and testbench

- Sequential front end for the ten-operand CSA summation tree.
- Accepts a serial stream of N-bit operands over a valid/ready handshake and packs them into a ten-slot register frame.
- Presents the frame on in0..in9 and holds it stable while the downstream combinational adder settles.
- Releases the frame on a consumer acknowledge; also supports flushing a partial frame, with unused slots zero-padded.

---
 rtl/csa_operand_collector.sv | 119 +++++++++++
 tb/tb_csa_operand_collector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/csa_operand_collector.sv
// Operand collector feeding the ten-operand CSA summation tree: packs a serial
// valid/ready operand stream into a ten-slot frame and holds it until acknowledged.
module csa_operand_collector #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] op_in,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic         flush,
    input  logic         frame_ack,
    output logic         frame_valid,
    output logic [3:0]   frame_count,
    output logic [N-1:0] in0,
    output logic [N-1:0] in1,
    output logic [N-1:0] in2,
    output logic [N-1:0] in3,
    output logic [N-1:0] in4,
    output logic [N-1:0] in5,
    output logic [N-1:0] in6,
    output logic [N-1:0] in7,
    output logic [N-1:0] in8,
    output logic [N-1:0] in9
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_idx;
    logic [3:0]   w_idx_next;
    logic [3:0]   r_count;
    logic [3:0]   w_count_next;
    logic         r_frame_valid;
    logic         w_frame_valid_next;
    logic         w_accept;
    logic         w_clear;
    logic [N-1:0] r_slot [10];

    assign op_ready = (r_state == FILL);
    assign w_accept = op_valid && (r_state == FILL);

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_count_next       = r_count;
        w_frame_valid_next = r_frame_valid;
        w_clear            = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_idx_next   = r_idx + 4'd1;
                    w_count_next = r_idx + 4'd1;
                end
                // A same-cycle accept counts toward a non-empty flush.
                if ((w_accept && (r_idx == 4'd9)) ||
                    (flush && ((r_idx != 4'd0) || w_accept))) begin
                    w_state_next       = HOLD;
                    w_frame_valid_next = 1'b1;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    w_state_next       = FILL;
                    w_idx_next         = 4'd0;
                    w_count_next       = 4'd0;
                    w_frame_valid_next = 1'b0;
                    w_clear            = 1'b1;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_count       <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_count       <= w_count_next;
            r_frame_valid <= w_frame_valid_next;
        end
    end

    // Slots clear on ack so unused positions read as zero in the next frame.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 10; i++) begin
            if (rst || w_clear) begin
                r_slot[i] <= '0;
            end else if (w_accept && (r_idx == 4'(i))) begin
                r_slot[i] <= op_in;
            end
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_count = r_count;
    assign in0 = r_slot[0];
    assign in1 = r_slot[1];
    assign in2 = r_slot[2];
    assign in3 = r_slot[3];
    assign in4 = r_slot[4];
    assign in5 = r_slot[5];
    assign in6 = r_slot[6];
    assign in7 = r_slot[7];
    assign in8 = r_slot[8];
    assign in9 = r_slot[9];

endmodule

// File: tb/tb_csa_operand_collector.sv
// Scoreboard bench for csa_operand_collector: a queue-based operand model predicts
// frames; a monitor checks every cycle against it.
module tb_csa_operand_collector;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0]      cnt;
        logic [10*N-1:0] slots;
        logic [31:0]     sum;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] op_in = '0;
    logic         op_valid = 1'b0;
    logic         flush = 1'b0;
    logic         frame_ack = 1'b0;
    logic         op_ready;
    logic         frame_valid;
    logic [3:0]   frame_count;
    logic [N-1:0] in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;

    always #5 clk = ~clk;

    csa_operand_collector #(.N(N)) dut (
        .clk(clk), .rst(rst), .op_in(op_in), .op_valid(op_valid), .op_ready(op_ready),
        .flush(flush), .frame_ack(frame_ack), .frame_valid(frame_valid),
        .frame_count(frame_count),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in5(in5), .in6(in6), .in7(in7), .in8(in8), .in9(in9)
    );

    // Model state: operands captured so far, and whether a frame is being held.
    logic [N-1:0] m_cur[$];
    bit           m_hold = 1'b0;
    frame_t       sb[$];
    bit           b2b = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10*N-1:0] pack_cur();
        logic [10*N-1:0] p;
        p = '0;
        foreach (m_cur[i]) p[i*N +: N] = m_cur[i];
        return p;
    endfunction

    function automatic logic [31:0] sum_cur();
        logic [31:0] s;
        s = 0;
        foreach (m_cur[i]) s += 32'(m_cur[i]);
        return s;
    endfunction

    function automatic logic [10*N-1:0] dut_slots();
        return {in9, in8, in7, in6, in5, in4, in3, in2, in1, in0};
    endfunction

    function automatic logic [31:0] dut_sum();
        return 32'(in0) + 32'(in1) + 32'(in2) + 32'(in3) + 32'(in4) +
               32'(in5) + 32'(in6) + 32'(in7) + 32'(in8) + 32'(in9);
    endfunction

    task automatic cycle(input bit r, input bit v, input logic [N-1:0] d,
                         input bit fl, input bit ak);
        frame_t e;
        @(negedge clk);
        rst = r; op_valid = v; op_in = d; flush = fl; frame_ack = ak;
        #1;
        check("op_ready", {63'd0, op_ready}, {63'd0, !m_hold});
        @(posedge clk);
        n_vec++;
        if (r) begin
            m_cur.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (ak) begin
                m_hold = 1'b0;
                m_cur.delete();
            end
        end else begin
            if (v) m_cur.push_back(d);
            if (m_cur.size() == 10 || (fl && m_cur.size() > 0)) begin
                m_hold  = 1'b1;
                e.cnt   = 4'(m_cur.size());
                e.slots = pack_cur();
                e.sum   = sum_cur();
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: frame closes popped from the scoreboard, held frames checked for
    // stability, and the filling frame checked against the operand queue.
    initial begin
        frame_t e, snap;
        bit     prev_fv = 1'b0;
        int     cyc = 0;
        int     last_rise = 0;
        bit     last_rise_b2b = 1'b0;
        snap = '0;
        @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            check("frame_valid", {63'd0, frame_valid}, {63'd0, m_hold});
            if (frame_valid && !prev_fv) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected: got frame_valid=1 expected no frame (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("frame_count", 64'(frame_count), 64'(e.cnt));
                    check("frame_slots", 64'(dut_slots()), 64'(e.slots));
                    check("frame_sum", 64'(dut_sum()), 64'(e.sum));
                    snap = e;
                end
                if (b2b && last_rise_b2b) check("b2b_gap", 64'(cyc - last_rise), 64'd11);
                last_rise     = cyc;
                last_rise_b2b = b2b;
            end else if (frame_valid) begin
                check("hold_count", 64'(frame_count), 64'(snap.cnt));
                check("hold_slots", 64'(dut_slots()), 64'(snap.slots));
            end else begin
                check("fill_count", 64'(frame_count), 64'(m_cur.size()));
                check("fill_slots", 64'(dut_slots()), 64'(pack_cur()));
            end
            prev_fv = frame_valid;
        end
    end

    initial begin
        cycle(1, 0, '0, 0, 0);
        cycle(1, 0, '0, 0, 0);
        // Full frame 1..10, then held against pressure, then ack and reuse.
        for (int i = 1; i <= 10; i++) cycle(0, 1, N'(i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'd15, 1, 0);
        cycle(0, 1, 4'd15, 0, 1);
        cycle(0, 1, 4'd15, 0, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 0, 1);
        // Partial frames: flush alone, and flush with a same-cycle accept.
        cycle(0, 1, 4'd7, 0, 0);
        cycle(0, 1, 4'd8, 0, 0);
        cycle(0, 1, 4'd9, 0, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'd2, 0, 0);
        cycle(0, 1, 4'd5, 1, 0);
        cycle(0, 0, '0, 0, 1);
        // Empty flush is ignored; ack in FILL is ignored.
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 1);
        // Reset discards a partial frame.
        for (int i = 0; i < 5; i++) cycle(0, 1, N'(i + 4), 0, 0);
        cycle(1, 1, 4'd6, 1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 4'd3, 0, 0);
        cycle(0, 0, '0, 0, 1);
        // Back-to-back frames with ack raised as soon as the frame is seen.
        cycle(1, 0, '0, 0, 0);
        b2b = 1'b1;
        for (int i = 0; i < 25; i++) cycle(0, 1, N'($urandom), 0, m_hold);
        b2b = 1'b0;
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 60) == 0, ($urandom % 4) != 0, N'($urandom),
                  ($urandom % 8) == 0, m_hold ? (($urandom % 3) == 0) : (($urandom % 2) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, 1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
